// File: rtl/run_sequence_ctrl_pkg.sv
// ============================================================================
//  Module      : run_sequence_ctrl_pkg
//  Description : Stage state codes and the run-loop exit rule shared by the
//                CAVLC run_before / level-run sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_sequence_ctrl_pkg;

    // Stage codes seen by the run datapath; the idle code is reserved here.
    localparam logic [3:0] c_RUN_CTRL_IDLE         = 4'b1111;
    localparam logic [3:0] c_RUN_BEFORE_LUT        = 4'b1000;
    localparam logic [3:0] c_RUN_OF_ZEROS          = 4'b1001;
    localparam logic [3:0] c_LEVEL_RUN_COMBINATION = 4'b1010;

    // The run_before loop stops once no further codeword can follow.
    function automatic logic run_loop_last(
        input logic [4:0] total_coeff,
        input logic [3:0] total_zeros,
        input logic [3:0] zeros_left,
        input logic [3:0] idx
    );
        return (total_coeff == 5'd1) || (total_zeros == 4'd0) ||
               (zeros_left == 4'd0) || ({1'b0, idx} == (total_coeff - 5'd2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/run_sequence_ctrl.sv
// ============================================================================
//  Module      : run_sequence_ctrl
//  Description : Sequences run_before decoding and level/run combination for
//                one CAVLC residual block, pacing bitstream consumption.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_sequence_ctrl
    import run_sequence_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] TotalCoeff,
    input  logic [3:0] total_zeros,
    input  logic       bs_ready,
    input  logic [3:0] run_of_zeros_len,
    input  logic [3:0] zerosLeft,
    input  logic [3:0] run,
    output logic [3:0] run_state,
    output logic [3:0] i_run,
    output logic       IsRunLoop,
    output logic [3:0] i_TotalCoeff,
    output logic [3:0] coeffNum,
    output logic [3:0] bs_advance,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LUT   = 3'd1;
    localparam logic [2:0] c_S_ZEROS = 3'd2;
    localparam logic [2:0] c_S_COMB  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [3:0] r_i_run;
    logic [3:0] r_i_total_coeff;
    logic [4:0] r_acc;
    logic       r_is_run_loop;
    logic       w_loop_last;

    assign w_loop_last = run_loop_last(TotalCoeff, total_zeros, zerosLeft, r_i_run);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_run         <= 4'd0;
            r_i_total_coeff <= 4'd0;
            r_acc           <= 5'd0;
            r_is_run_loop   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_i_run       <= 4'd0;
                        r_is_run_loop <= 1'b0;
                        r_acc         <= 5'd0;
                    end
                end
                c_S_ZEROS: begin
                    if (w_loop_last) begin
                        r_i_total_coeff <= 4'(TotalCoeff - 5'd1);
                        r_acc           <= 5'd0;
                    end else begin
                        r_i_run       <= r_i_run + 4'd1;
                        r_is_run_loop <= 1'b1;
                    end
                end
                c_S_COMB: begin
                    // Accumulator tracks the scan position just past the last written coefficient.
                    r_acc <= r_acc + {1'b0, run} + 5'd1;
                    if (r_i_total_coeff != 4'd0) begin
                        r_i_total_coeff <= r_i_total_coeff - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_next_state = (TotalCoeff == 5'd0) ? c_S_DONE : c_S_LUT;
                end
            end
            c_S_LUT: begin
                if (bs_ready) begin
                    w_next_state = c_S_ZEROS;
                end
            end
            c_S_ZEROS: begin
                w_next_state = w_loop_last ? c_S_COMB : c_S_LUT;
            end
            c_S_COMB: begin
                if (r_i_total_coeff == 4'd0) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        run_state  = c_RUN_CTRL_IDLE;
        coeffNum   = 4'd0;
        bs_advance = 4'd0;
        busy       = (r_state != c_S_IDLE);
        done       = (r_state == c_S_DONE);
        case (r_state)
            c_S_LUT: begin
                run_state  = c_RUN_BEFORE_LUT;
                bs_advance = bs_ready ? run_of_zeros_len : 4'd0;
            end
            c_S_ZEROS: begin
                run_state = c_RUN_OF_ZEROS;
            end
            c_S_COMB: begin
                run_state = c_LEVEL_RUN_COMBINATION;
                coeffNum  = r_acc[3:0] + run;
            end
            default: begin
            end
        endcase
    end

    assign i_run        = r_i_run;
    assign IsRunLoop    = r_is_run_loop;
    assign i_TotalCoeff = r_i_total_coeff;

endmodule

`default_nettype wire
